obj_affine_fetch: RTL and testbench
===================================

Name: obj_affine_fetch

Overview:
Per-object attribute fetch sequencer for the OBJ pipeline. On a start request it reads one object's OAM entry and, for affine objects, its PA/PB/PC/PD parameter group from OAM. It decodes position, bounding size and the double-size flag, then presents them on a valid/ready output. The output feeds the object rotation/scale unit directly: objx, objy, hsize, vsize, dblsize and a/b/c/d.

Parameters:
OAM_AW, 8, OAM word address width (256 x 32-bit words)
IDENT, 16'h0100, affine parameter value driven on a and d for non-affine objects (1.0 in 8.8)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  fetch request; accepted only when start_ready=1
start_ready  out  1  high in IDLE only
obj_idx  in  7  object number 0..127, sampled when start is accepted
oam_addr  out  8  OAM word address
oam_rd  out  1  OAM read strobe
oam_rdata  in  32  OAM read data, valid the cycle after oam_addr/oam_rd
out_valid  out  1  fetched object available
out_ready  in  1  consumer accepts the object
objx  out  9  attr1[8:0]
objy  out  8  attr0[7:0]
hsize  out  8  bounding width in pixels (sprite width << dblsize)
vsize  out  8  bounding height in pixels (sprite height << dblsize)
dblsize  out  1  attr0[9] when affine, else 0
affine  out  1  attr0[8]
hidden  out  1  non-affine and attr0[9]=1
attr2  out  16  tile/priority/palette halfword, passed through
a, b, c, d  out  16 each  PA/PB/PC/PD as raw two's-complement 8.8

Behaviour:
- Reset: state=IDLE. out_valid=0, oam_rd=0, oam_addr=0. All attribute outputs are 0. a=d=IDENT, b=c=0.
- OAM has a fixed 1-cycle read latency. The address issued in state S is captured in the state after S.
- Object i layout: word 2i holds attr0 in [15:0] and attr1 in [31:16]. Word 2i+1 holds attr2 in [15:0].
- Group g = attr1[13:9]. PA/PB/PC/PD are at words 8g+1, 8g+3, 8g+5, 8g+7, bits [31:16].
- FSM, one state per cycle:
  - IDLE: if start, latch obj_idx and go RD0.
  - RD0: oam_rd=1, addr=2i; go RD1.
  - RD1: oam_rd=1, addr=2i+1; capture attr0/attr1; go RD2.
  - RD2: capture attr2.
    - If attr0[8]=1: oam_rd=1, addr=8g+1; go PB.
    - Else: a=d=IDENT, b=c=0; go DONE.
  - PB: capture a; addr=8g+3; go PC.
  - PC: capture b; addr=8g+5; go PD.
  - PD: capture c; addr=8g+7; go PDL.
  - PDL: capture d; oam_rd=0; go DONE.
  - DONE: out_valid=1. When out_valid and out_ready, go IDLE; out_valid drops the next cycle.
- Latency from the start-accept edge to out_valid: 4 cycles for non-affine, 8 cycles for affine.
- oam_rd=0 in IDLE, DONE and PDL. oam_addr holds its last value when oam_rd=0.
- Outputs stay stable while out_valid=1 and out_ready=0. The stall is indefinite.
- start while busy (not IDLE) is ignored, not queued.
- start in the same cycle as the DONE handshake is ignored; start_ready is still 0 that cycle.
- Size decode, indexed by shape=attr0[15:14] and size=attr1[15:14], in pixels w x h:
  - shape 0: 8x8, 16x16, 32x32, 64x64
  - shape 1: 16x8, 32x8, 32x16, 64x32
  - shape 2: 8x16, 8x32, 16x32, 32x64
  - shape 3 (prohibited): 8x8
- hsize/vsize are the decoded size, shifted left by 1 when dblsize=1. Maximum is 128; 8 bits, no overflow.
- For non-affine objects, attr1[13:12] are flip bits and are not used for the group. No parameter reads occur.
- Address arithmetic wraps modulo 256: obj 127 gives words 254/255; g=31 gives words 249..255.
- Reset in any state returns to IDLE next cycle with reset values. Any partial fetch is discarded.

Test Plan:
- Non-affine fetch, obj 3: word6=0x4064_8020 (attr0=0x8020, attr1=0x4064), word7=0x0123. Pulse start at cycle 0. Required: out_valid at cycle 4; objx=0x064, objy=0x20; shape 2, size 1 gives hsize=8, vsize=32; affine=0, hidden=0; attr2=0x0123; a=d=0x0100, b=c=0. Exactly 2 OAM reads (6, 7).
- Affine double-size, obj 0: attr0=0x0310 (affine, dbl, y=0x10), attr1=0x8A05 (g=5, size 2, x=5), shape 0. Params: word41[31:16]=0x0080, word43=0xFF00, word45=0x0040, word47=0x0200. Required: out_valid at cycle 8; hsize=vsize=64; dblsize=1; a=0x0080, b=0xFF00, c=0x0040, d=0x0200. OAM read address sequence 0,1,41,43,45,47.
- Hidden object: attr0 bit9=1, bit8=0. Required: hidden=1, dblsize=0, and no parameter reads.
- Backpressure: out_ready=0 for 10 cycles after out_valid. Required: outputs stable and start ignored throughout. Assert out_ready: out_valid drops next cycle, and start_ready=1 that same cycle.
- Wrap and prohibited shape: obj 127 with shape 3. Required: OAM reads 254, 255 and hsize=vsize=8. Affine g=31: parameter reads 249, 251, 253, 255.
- Reset during PC state. Required: next cycle IDLE, out_valid=0, a=d=0x0100, start_ready=1. A new start then completes normally.

Source files
------------

// File: rtl/obj_affine_fetch_if.sv
// Signal bundle between the OBJ fetch sequencer, the OAM read port and the
// rotation/scale consumer. The fetch unit uses the master view.
interface obj_affine_fetch_if #(
    parameter int OAM_AW = 8
) ();
    logic              start;
    logic              start_ready;
    logic [6:0]        obj_idx;
    logic [OAM_AW-1:0] oam_addr;
    logic              oam_rd;
    logic [31:0]       oam_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [8:0]        objx;
    logic [7:0]        objy;
    logic [7:0]        hsize;
    logic [7:0]        vsize;
    logic              dblsize;
    logic              affine;
    logic              hidden;
    logic [15:0]       attr2;
    logic [15:0]       a;
    logic [15:0]       b;
    logic [15:0]       c;
    logic [15:0]       d;

    modport master (
        input  start, obj_idx, oam_rdata, out_ready,
        output start_ready, oam_addr, oam_rd, out_valid,
               objx, objy, hsize, vsize, dblsize, affine, hidden, attr2, a, b, c, d
    );

    modport slave (
        output start, obj_idx, oam_rdata, out_ready,
        input  start_ready, oam_addr, oam_rd, out_valid,
               objx, objy, hsize, vsize, dblsize, affine, hidden, attr2, a, b, c, d
    );
endinterface

// File: rtl/obj_affine_fetch.sv
// Per-object OAM attribute fetch: reads attr0/1/2 and, for affine objects,
// the PA..PD group, then holds the decoded object on a valid/ready output.
module obj_affine_fetch #(
    parameter int          OAM_AW = 8,
    parameter logic [15:0] IDENT  = 16'h0100
) (
    input  logic              clock,
    input  logic              reset,
    obj_affine_fetch_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_PB, S_PC, S_PD, S_PDL, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [6:0]        idx_q, idx_d;
    logic [OAM_AW-1:0] oam_addr_q, oam_addr_d;
    logic [8:0]        objx_q, objx_d;
    logic [7:0]        objy_q, objy_d;
    logic [7:0]        hsize_q, hsize_d;
    logic [7:0]        vsize_q, vsize_d;
    logic              dbl_q, dbl_d;
    logic              affine_q, affine_d;
    logic              hidden_q, hidden_d;
    logic [4:0]        group_q, group_d;
    logic [15:0]       attr2_q, attr2_d;
    logic [15:0]       a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;

    logic              oam_rd;
    logic [7:0]        rd_addr;
    logic [15:0]       rd_attr0, rd_attr1;
    logic [13:0]       rd_wh;
    logic              rd_dbl;
    logic              unused_attr0_bits;

    // Returns {width, height} in pixels; the prohibited shape decodes as 8x8.
    function automatic logic [13:0] size_decode(input logic [1:0] shape, input logic [1:0] size);
        logic [6:0] w;
        logic [6:0] h;
        case ({shape, size})
            4'b00_00: begin w = 7'd8;  h = 7'd8;  end
            4'b00_01: begin w = 7'd16; h = 7'd16; end
            4'b00_10: begin w = 7'd32; h = 7'd32; end
            4'b00_11: begin w = 7'd64; h = 7'd64; end
            4'b01_00: begin w = 7'd16; h = 7'd8;  end
            4'b01_01: begin w = 7'd32; h = 7'd8;  end
            4'b01_10: begin w = 7'd32; h = 7'd16; end
            4'b01_11: begin w = 7'd64; h = 7'd32; end
            4'b10_00: begin w = 7'd8;  h = 7'd16; end
            4'b10_01: begin w = 7'd8;  h = 7'd32; end
            4'b10_10: begin w = 7'd16; h = 7'd32; end
            4'b10_11: begin w = 7'd32; h = 7'd64; end
            default:  begin w = 7'd8;  h = 7'd8;  end
        endcase
        return {w, h};
    endfunction

    assign rd_attr0          = bus.oam_rdata[15:0];
    assign rd_attr1          = bus.oam_rdata[31:16];
    assign rd_wh             = size_decode(rd_attr0[15:14], rd_attr1[15:14]);
    assign rd_dbl            = rd_attr0[9] & rd_attr0[8];
    assign unused_attr0_bits = ^rd_attr0[13:10];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            oam_addr_q <= '0;
            objx_q     <= '0;
            objy_q     <= '0;
            hsize_q    <= '0;
            vsize_q    <= '0;
            dbl_q      <= 1'b0;
            affine_q   <= 1'b0;
            hidden_q   <= 1'b0;
            group_q    <= '0;
            attr2_q    <= '0;
            a_q        <= IDENT;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= IDENT;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            oam_addr_q <= oam_addr_d;
            objx_q     <= objx_d;
            objy_q     <= objy_d;
            hsize_q    <= hsize_d;
            vsize_q    <= vsize_d;
            dbl_q      <= dbl_d;
            affine_q   <= affine_d;
            hidden_q   <= hidden_d;
            group_q    <= group_d;
            attr2_q    <= attr2_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RD0;
            S_RD0:   state_d = S_RD1;
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = affine_q ? S_PB : S_DONE;
            S_PB:    state_d = S_PC;
            S_PC:    state_d = S_PD;
            S_PD:    state_d = S_PDL;
            S_PDL:   state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address issued in one state returns data in the next; the address holds between reads.
    always_comb begin
        oam_rd  = 1'b0;
        rd_addr = 8'h00;
        case (state_q)
            S_RD0: begin oam_rd = 1'b1; rd_addr = {idx_q, 1'b0}; end
            S_RD1: begin oam_rd = 1'b1; rd_addr = {idx_q, 1'b1}; end
            S_RD2: if (affine_q) begin oam_rd = 1'b1; rd_addr = {group_q, 3'd1}; end
            S_PB:  begin oam_rd = 1'b1; rd_addr = {group_q, 3'd3}; end
            S_PC:  begin oam_rd = 1'b1; rd_addr = {group_q, 3'd5}; end
            S_PD:  begin oam_rd = 1'b1; rd_addr = {group_q, 3'd7}; end
            default: ;
        endcase
        oam_addr_d = oam_rd ? OAM_AW'(rd_addr) : oam_addr_q;
    end

    always_comb begin
        idx_d    = idx_q;
        objx_d   = objx_q;
        objy_d   = objy_q;
        hsize_d  = hsize_q;
        vsize_d  = vsize_q;
        dbl_d    = dbl_q;
        affine_d = affine_q;
        hidden_d = hidden_q;
        group_d  = group_q;
        attr2_d  = attr2_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        case (state_q)
            S_IDLE: if (bus.start) idx_d = bus.obj_idx;
            S_RD1: begin
                objx_d   = rd_attr1[8:0];
                objy_d   = rd_attr0[7:0];
                affine_d = rd_attr0[8];
                dbl_d    = rd_dbl;
                hidden_d = ~rd_attr0[8] & rd_attr0[9];
                group_d  = rd_attr1[13:9];
                hsize_d  = rd_dbl ? {rd_wh[13:7], 1'b0} : {1'b0, rd_wh[13:7]};
                vsize_d  = rd_dbl ? {rd_wh[6:0], 1'b0}  : {1'b0, rd_wh[6:0]};
            end
            S_RD2: begin
                attr2_d = bus.oam_rdata[15:0];
                if (!affine_q) begin
                    a_d = IDENT;
                    b_d = '0;
                    c_d = '0;
                    d_d = IDENT;
                end
            end
            S_PB:  a_d = bus.oam_rdata[31:16];
            S_PC:  b_d = bus.oam_rdata[31:16];
            S_PD:  c_d = bus.oam_rdata[31:16];
            S_PDL: d_d = bus.oam_rdata[31:16];
            default: ;
        endcase
    end

    assign bus.start_ready = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.oam_rd      = oam_rd;
    assign bus.oam_addr    = oam_addr_d;
    assign bus.objx        = objx_q;
    assign bus.objy        = objy_q;
    assign bus.hsize       = hsize_q;
    assign bus.vsize       = vsize_q;
    assign bus.dblsize     = dbl_q;
    assign bus.affine      = affine_q;
    assign bus.hidden      = hidden_q;
    assign bus.attr2       = attr2_q;
    assign bus.a           = a_q;
    assign bus.b           = b_q;
    assign bus.c           = c_q;
    assign bus.d           = d_q;
endmodule

// File: tb/tb_obj_affine_fetch.sv
// Directed bench for obj_affine_fetch: behavioural OAM with 1-cycle latency,
// read-address log, hand-computed expected objects.
module tb_obj_affine_fetch;
    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] oam_mem [0:255];
    logic [7:0]  rd_log [$];

    obj_affine_fetch_if bus ();

    obj_affine_fetch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        bus.oam_rdata <= oam_mem[bus.oam_addr];
        if (bus.oam_rd) rd_log.push_back(bus.oam_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Pulses start for one edge, then counts edges until out_valid (accept edge = 1).
    task automatic fetch(input logic [6:0] idx, output int lat);
        bus.start   = 1'b1;
        bus.obj_idx = idx;
        @(negedge clock);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clock);
        check({tag, "_valid_drop"}, bus.out_valid, 1'b0);
        check({tag, "_start_ready"}, bus.start_ready, 1'b1);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_obj(input string tag, input logic [8:0] x, input logic [7:0] y,
                             input logic [7:0] hs, input logic [7:0] vs, input logic [2:0] dah,
                             input logic [15:0] at2, input logic [63:0] abcd);
        check({tag, "_objx"}, bus.objx, x);
        check({tag, "_objy"}, bus.objy, y);
        check({tag, "_hsize"}, bus.hsize, hs);
        check({tag, "_vsize"}, bus.vsize, vs);
        check({tag, "_dbl_aff_hid"}, {bus.dblsize, bus.affine, bus.hidden}, dah);
        check({tag, "_attr2"}, bus.attr2, at2);
        check({tag, "_abcd"}, {bus.a, bus.b, bus.c, bus.d}, abcd);
    endtask

    task automatic check_reads(input string tag, input int n, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                               input logic [7:0] e5);
        logic [7:0] e [6];
        e = '{e0, e1, e2, e3, e4, e5};
        check({tag, "_nreads"}, rd_log.size(), n);
        for (int i = 0; i < n; i++)
            if (i < rd_log.size()) check($sformatf("%s_read%0d", tag, i), rd_log[i], e[i]);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) oam_mem[i] = 32'h0;
        oam_mem[6]   = 32'h4064_8020;  // obj 3: shape 2 size 1, non-affine
        oam_mem[7]   = 32'h0000_0123;
        oam_mem[0]   = 32'h8A05_0310;  // obj 0: affine, dbl, group 5
        oam_mem[1]   = 32'h0000_5A5A;
        oam_mem[41]  = 32'h0080_1111;
        oam_mem[43]  = 32'hFF00_2222;
        oam_mem[45]  = 32'h0040_3333;
        oam_mem[47]  = 32'h0200_4444;
        oam_mem[20]  = 32'h3E07_0230;  // obj 10: hidden, attr1[13:9] all ones
        oam_mem[21]  = 32'h0000_0A0A;
        oam_mem[10]  = 32'hC1FF_40FF;  // obj 5: shape 1 size 3
        oam_mem[11]  = 32'h0000_BEEF;
        oam_mem[254] = 32'h4010_C040;  // obj 127: prohibited shape
        oam_mem[255] = 32'h0300_0077;
        oam_mem[128] = 32'h7E00_0105;  // obj 64: affine, group 31
        oam_mem[249] = 32'h1234_0000;
        oam_mem[251] = 32'h8000_0000;
        oam_mem[253] = 32'h7FFF_0000;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.obj_idx   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_rd", bus.oam_rd, 1'b0);
        check("rst_addr", bus.oam_addr, 8'h00);
        check("rst_start_ready", bus.start_ready, 1'b1);
        check_obj("rst", 9'h0, 8'h0, 8'h0, 8'h0, 3'b000, 16'h0, 64'h0100_0000_0000_0100);
        reset = 1'b0;

        rd_log.delete();
        fetch(7'd3, lat);
        check("na_latency", lat, 4);
        check_obj("na", 9'h064, 8'h20, 8'd8, 8'd32, 3'b000, 16'h0123, 64'h0100_0000_0000_0100);
        check_reads("na", 2, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0);
        handshake("na");

        rd_log.delete();
        fetch(7'd0, lat);
        check("aff_latency", lat, 8);
        check_obj("aff", 9'h005, 8'h10, 8'd64, 8'd64, 3'b110, 16'h5A5A, 64'h0080_FF00_0040_0200);
        check_reads("aff", 6, 8'd0, 8'd1, 8'd41, 8'd43, 8'd45, 8'd47);
        handshake("aff");

        rd_log.delete();
        fetch(7'd10, lat);
        check("hid_latency", lat, 4);
        check_obj("hid", 9'h007, 8'h30, 8'd8, 8'd8, 3'b001, 16'h0A0A, 64'h0100_0000_0000_0100);
        check_reads("hid", 2, 8'd20, 8'd21, 8'd0, 8'd0, 8'd0, 8'd0);
        handshake("hid");

        rd_log.delete();
        fetch(7'd5, lat);
        check("bp_latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            bus.start   = 1'b1;
            bus.obj_idx = 7'd0;
            @(negedge clock);
            check($sformatf("bp_valid%0d", i), bus.out_valid, 1'b1);
            check($sformatf("bp_start_ready%0d", i), bus.start_ready, 1'b0);
            check($sformatf("bp_fields%0d", i), {bus.objx, bus.objy, bus.hsize, bus.vsize, bus.attr2},
                  {9'h1FF, 8'hFF, 8'd64, 8'd32, 16'hBEEF});
        end
        handshake("bp");
        bus.start = 1'b0;
        check_reads("bp", 2, 8'd10, 8'd11, 8'd0, 8'd0, 8'd0, 8'd0);

        rd_log.delete();
        fetch(7'd127, lat);
        check("wrap_latency", lat, 4);
        check_obj("wrap", 9'h010, 8'h40, 8'd8, 8'd8, 3'b000, 16'h0077, 64'h0100_0000_0000_0100);
        check_reads("wrap", 2, 8'd254, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0);
        handshake("wrap");

        rd_log.delete();
        fetch(7'd64, lat);
        check("g31_latency", lat, 8);
        check_obj("g31", 9'h000, 8'h05, 8'd16, 8'd16, 3'b010, 16'h0000, 64'h1234_8000_7FFF_0300);
        check_reads("g31", 6, 8'd128, 8'd129, 8'd249, 8'd251, 8'd253, 8'd255);
        handshake("g31");

        // Abort an affine fetch in PC: accept edge + 4 edges.
        bus.start   = 1'b1;
        bus.obj_idx = 7'd0;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        check("pc_rd_addr", bus.oam_addr, 8'd45);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rstpc_valid", bus.out_valid, 1'b0);
        check("rstpc_start_ready", bus.start_ready, 1'b1);
        check("rstpc_rd", bus.oam_rd, 1'b0);
        check("rstpc_abcd", {bus.a, bus.b, bus.c, bus.d}, 64'h0100_0000_0000_0100);
        rd_log.delete();
        fetch(7'd3, lat);
        check("after_rst_latency", lat, 4);
        check_obj("after_rst", 9'h064, 8'h20, 8'd8, 8'd32, 3'b000, 16'h0123, 64'h0100_0000_0000_0100);
        check_reads("after_rst", 2, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0);
        handshake("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
